// File: rtl/ac_config_sequencer.sv
// SSM2603 bring-up sequencer: walks the codec register sequence through an I2C master, then forwards user writes.
// Optional user-write path compiled in with `define AC_CFG_USER_WRITE_EN.
module ac_config_sequencer #(
  parameter string      INTERFACE_TYPE = "I2S",
  parameter int         DATA_WDT       = 24,
  parameter int         SETTLE_CYCLES  = 2_500_000,
  parameter int         MAX_RETRIES    = 3,
  parameter logic [6:0] DEV_ADDR       = 7'h1A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        i2cReq,
  output logic [6:0]  i2cDev,
  output logic [15:0] i2cData,
  input  logic        i2cAck,
  input  logic        i2cNack,
  input  logic        userReq,
  input  logic [6:0]  userRegAddr,
  input  logic [8:0]  userRegData,
  output logic        userAck,
  output logic        modEn,
  output logic        busy,
  output logic        done,
  output logic        error
);

  if (INTERFACE_TYPE != "LEFT-JUSTIFIED" && INTERFACE_TYPE != "RIGHT-JUSTIFIED" &&
      INTERFACE_TYPE != "I2S") begin : g_bad_if_type
    $error("ac_config_sequencer: unsupported INTERFACE_TYPE");
  end
  if (DATA_WDT != 16 && DATA_WDT != 20 && DATA_WDT != 24 && DATA_WDT != 32) begin : g_bad_wdt
    $error("ac_config_sequencer: unsupported DATA_WDT");
  end

  localparam logic [1:0] FMT_MODE = (INTERFACE_TYPE == "I2S")            ? 2'b10 :
                                    (INTERFACE_TYPE == "LEFT-JUSTIFIED") ? 2'b01 : 2'b00;
  localparam logic [1:0] FMT_WDT  = (DATA_WDT == 16) ? 2'b00 : (DATA_WDT == 20) ? 2'b01 :
                                    (DATA_WDT == 24) ? 2'b10 : 2'b11;
  localparam logic [8:0] FMT      = {5'b00000, FMT_WDT, FMT_MODE};
  localparam int RETRY_W  = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_SETTLE, S_READY, S_UWAIT, S_ERROR
  } state_t;

  state_t                r_state,      w_state_next;
  logic [3:0]            r_step,       w_step_next;
  logic [RETRY_W-1:0]    r_retry,      w_retry_next;
  logic [SETTLE_W-1:0]   r_settle_cnt, w_settle_next;
  logic [15:0]           r_data,       w_data_next;
  logic                  r_done,       w_done_next;
  logic                  r_user_ack,   w_user_ack_next;

  // Step 10 is the VMID settle wait and has no register write.
  function automatic logic [15:0] step_word(input logic [3:0] step);
    case (step)
      4'd0:    step_word = {7'd15, 9'h000};
      4'd1:    step_word = {7'd6,  9'h072};
      4'd2:    step_word = {7'd0,  9'h017};
      4'd3:    step_word = {7'd1,  9'h017};
      4'd4:    step_word = {7'd2,  9'h079};
      4'd5:    step_word = {7'd3,  9'h079};
      4'd6:    step_word = {7'd4,  9'h012};
      4'd7:    step_word = {7'd5,  9'h000};
      4'd8:    step_word = {7'd7,  FMT};
      4'd9:    step_word = {7'd8,  9'h000};
      4'd11:   step_word = {7'd9,  9'h001};
      4'd12:   step_word = {7'd6,  9'h062};
      default: step_word = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_step       <= '0;
      r_retry      <= '0;
      r_settle_cnt <= '0;
      r_data       <= '0;
      r_done       <= 1'b0;
      r_user_ack   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_step       <= w_step_next;
      r_retry      <= w_retry_next;
      r_settle_cnt <= w_settle_next;
      r_data       <= w_data_next;
      r_done       <= w_done_next;
      r_user_ack   <= w_user_ack_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_step_next     = r_step;
    w_retry_next    = r_retry;
    w_settle_next   = r_settle_cnt;
    w_data_next     = r_data;
    w_done_next     = 1'b0;
    w_user_ack_next = 1'b0;
    case (r_state)
      S_IDLE, S_ERROR, S_READY: begin
        if (start) begin
          w_state_next = S_ISSUE;
          w_step_next  = 4'd0;
          w_retry_next = '0;
        end
`ifdef AC_CFG_USER_WRITE_EN
        else if (r_state == S_READY && userReq) begin
          w_state_next = S_UWAIT;
          w_data_next  = {userRegAddr, userRegData};
        end
`endif
      end
      S_ISSUE: begin
        w_data_next  = step_word(r_step);
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        // NACK wins when both responses arrive together.
        if (i2cNack) begin
          if (r_retry < RETRY_W'(MAX_RETRIES)) begin
            w_retry_next = r_retry + 1'b1;
            w_state_next = S_ISSUE;
          end else begin
            w_state_next = S_ERROR;
          end
        end else if (i2cAck) begin
          w_retry_next = '0;
          if (r_step == 4'd9) begin
            w_step_next   = 4'd10;
            w_settle_next = '0;
            w_state_next  = S_SETTLE;
          end else if (r_step == 4'd12) begin
            w_done_next  = 1'b1;
            w_state_next = S_READY;
          end else begin
            w_step_next  = r_step + 4'd1;
            w_state_next = S_ISSUE;
          end
        end
      end
      S_SETTLE: begin
        // Jump straight into the step-11 request so the idle time equals the settle length.
        if (r_settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          w_step_next  = 4'd11;
          w_data_next  = step_word(4'd11);
          w_state_next = S_WAIT;
        end else begin
          w_settle_next = r_settle_cnt + 1'b1;
        end
      end
      S_UWAIT: begin
        if (i2cAck || i2cNack) begin
          w_user_ack_next = 1'b1;
          w_state_next    = S_READY;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    i2cReq  = (r_state == S_WAIT) || (r_state == S_UWAIT);
    modEn   = (r_state == S_READY) || (r_state == S_UWAIT);
    busy    = (r_state == S_ISSUE) || (r_state == S_WAIT) ||
              (r_state == S_SETTLE) || (r_state == S_UWAIT);
    error   = (r_state == S_ERROR);
    done    = r_done;
    userAck = r_user_ack;
    i2cData = r_data;
    i2cDev  = DEV_ADDR;
  end

`ifndef AC_CFG_USER_WRITE_EN
  logic w_unused_user;
  assign w_unused_user = ^{userReq, userRegAddr, userRegData};
`endif

endmodule

// File: tb/tb_ac_config_sequencer.sv
// Scoreboard bench for ac_config_sequencer: an I2C BFM answers requests, a monitor checks each issued word.
module tb_ac_config_sequencer;
  localparam int SETTLE = 10;

  logic        clk = 1'b0;
  logic        reset, start, i2cAck, i2cNack, userReq;
  logic [6:0]  userRegAddr;
  logic [8:0]  userRegData;
  logic        i2cReq, userAck, modEn, busy, done, error;
  logic [6:0]  i2cDev;
  logic [15:0] i2cData;

  ac_config_sequencer #(
    .INTERFACE_TYPE("I2S"), .DATA_WDT(24), .SETTLE_CYCLES(SETTLE),
    .MAX_RETRIES(3), .DEV_ADDR(7'h1A)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .i2cReq(i2cReq), .i2cDev(i2cDev), .i2cData(i2cData),
    .i2cAck(i2cAck), .i2cNack(i2cNack),
    .userReq(userReq), .userRegAddr(userRegAddr), .userRegData(userRegData),
    .userAck(userAck), .modEn(modEn), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] word;
    int          gap;   // expected idle samples before the request, -1 = unchecked
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] seq_words [12] = '{16'h1E00, 16'h0C72, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                  16'h0812, 16'h0A00, 16'h0E0A, 16'h1000, 16'h1201, 16'h0C62};

  logic [15:0] nack_word = 16'h0000;
  int          nack_left = 0;
  int          last_resp_cyc = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [15:0] w, input int g);
    exp_t e;
    e.word = w;
    e.gap  = g;
    exp_q.push_back(e);
  endtask

  task automatic push_seq(input int upto);
    for (int i = 0; i <= upto; i++)
      push(seq_words[i], (i == 0) ? -1 : (i == 10) ? SETTLE : 1);
  endtask

  // I2C master model: answers 3 cycles after a request, NACKing nack_word while nack_left > 0.
  initial begin : bfm
    int cnt;
    cnt = 0;
    i2cAck = 1'b0;
    i2cNack = 1'b0;
    forever begin
      @(negedge clk);
      i2cAck = 1'b0;
      i2cNack = 1'b0;
      if (i2cReq) begin
        cnt++;
        if (cnt == 3) begin
          if (nack_left > 0 && i2cData == nack_word) begin
            i2cNack = 1'b1;
            nack_left--;
          end else begin
            i2cAck = 1'b1;
          end
          last_resp_cyc = cyc;
          $display("resp cycle=%0d word=%h nack=%0d", cyc, i2cData, i2cNack);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : monitor
    logic prev;
    int   low;
    exp_t e;
    prev = 1'b0;
    low  = 0;
    forever begin
      @(negedge clk);
      if (i2cReq && !prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req: got %h want no request (cycle %0d)", i2cData, cyc);
        end else begin
          e = exp_q.pop_front();
          $display("req  cycle=%0d word=%h gap=%0d", cyc, i2cData, low);
          check("req_word", i2cData, e.word);
          if (e.gap >= 0) check("req_gap", low, e.gap);
        end
        low = 0;
      end else if (!i2cReq) begin
        low++;
      end
      prev = i2cReq;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_i2cReq"}, i2cReq, 0);
    check({tag, "_i2cData"}, i2cData, 0);
    check({tag, "_i2cDev"}, i2cDev, 7'h1A);
    check({tag, "_userAck"}, userAck, 0);
    check({tag, "_modEn"}, modEn, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input int remaining);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("done_latency", cyc - last_resp_cyc, 1);
      check("modEn_at_done", modEn, 1);
      check("error_at_done", error, 0);
      check("queue_at_done", exp_q.size(), remaining);
      @(negedge clk);
      check("done_one_cycle", done, 0);
    end
  endtask

  task automatic wait_user_ack(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (userAck) begin
        seen = 1'b1;
        break;
      end
    end
    check("userAck_seen", seen, 1);
    if (seen) begin
      check("userAck_latency", cyc - last_resp_cyc, 1);
      check("modEn_user", modEn, 1);
      userReq = 1'b0;
      @(negedge clk);
      check("userAck_pulse", userAck, 0);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    userReq = 1'b0;
    userRegAddr = 7'd0;
    userRegData = 9'd0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal bring-up.
    push_seq(11);
    pulse_start();
    check("busy_after_start", busy, 1);
    wait_done(400, 0);

    // One NACK on step 6; a start pulse while busy must be ignored.
    nack_word = 16'h0812;
    nack_left = 1;
    for (int i = 0; i < 12; i++) begin
      push(seq_words[i], (i == 0) ? -1 : (i == 10) ? SETTLE : 1);
      if (i == 6) push(16'h0812, 1);
    end
    pulse_start();
    repeat (5) @(negedge clk);
    pulse_start();
    wait_done(400, 0);
    check("nack_consumed", nack_left, 0);

    // Retries exhausted on step 2.
    nack_word = 16'h0017;
    nack_left = 4;
    push(16'h1E00, -1);
    push(16'h0C72, 1);
    repeat (4) push(16'h0017, 1);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (error) begin
        seen = 1'b1;
        break;
      end
    end
    check("error_set", seen, 1);
    check("modEn_in_error", modEn, 0);
    check("req_in_error", i2cReq, 0);
    repeat (30) @(negedge clk);
    check("error_sticky", error, 1);
    check("queue_in_error", exp_q.size(), 0);
    nack_left = 0;
    push_seq(11);
    pulse_start();
    check("error_cleared", error, 0);
    wait_done(400, 0);

`ifdef AC_CFG_USER_WRITE_EN
    // User write from READY.
    userRegAddr = 7'd2;
    userRegData = 9'h07F;
    push(16'h047F, -1);
    @(negedge clk) userReq = 1'b1;
    wait_user_ack(50);

    // User request raised during SETTLE waits for bring-up to finish.
    userRegData = 9'h055;
    push_seq(11);
    push(16'h0455, -1);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy && !i2cReq && exp_q.size() == 3) begin
        seen = 1'b1;
        break;
      end
    end
    check("reached_settle", seen, 1);
    userReq = 1'b1;
    check("no_userAck_in_settle", userAck, 0);
    wait_done(400, 1);
    wait_user_ack(50);
`else
    begin
      int reqs, acks;
      reqs = 0;
      acks = 0;
      userRegAddr = 7'd2;
      userRegData = 9'h07F;
      userReq = 1'b1;
      repeat (100) begin
        @(negedge clk);
        if (i2cReq) reqs++;
        if (userAck) acks++;
      end
      userReq = 1'b0;
      check("no_user_req", reqs, 0);
      check("no_user_ack", acks, 0);
      check("modEn_ready", modEn, 1);
    end
`endif

    // Reset during the step-5 write.
    push_seq(5);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        seen = 1'b1;
        break;
      end
    end
    check("step5_reached", seen, 1);
    check("step5_req", i2cReq, 1);
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    push_seq(11);
    pulse_start();
    wait_done(400, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
